tetris_engine: RTL

- Game-logic core of the Tetris VGA design. Sits directly upstream of vga_controller and drives its 400-bit field bus.
- Consumes the processed keyboard strobes (left/right/rotate/speed), the 3-bit LFSR value and tick enables derived from clkCounter.
- Owns the 10x20 board, the active tetromino, collision checking, locking, line clearing, the cleared-line counter and game over.

---
 rtl/tetris_engine.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_engine.sv
// Tetris game core: owns the locked board, the falling piece and the line counter,
// and publishes a registered 2-bit-per-cell field image for the VGA renderer.
module tetris_engine #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 3
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     tick_move,
    input  logic                     tick_fall,
    input  logic                     left_i,
    input  logic                     right_i,
    input  logic                     rotate_i,
    input  logic                     speed_i,
    input  logic [2:0]               random5,
    output logic [2*ROWS*COLS-1:0]   field,
    output logic [15:0]              lines,
    output logic                     game_over
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {S_SPAWN, S_PLAY, S_LOCK, S_CLEAR, S_GAMEOVER} state_t;

    state_t                    r_state, w_nextState;
    logic [ROWS-1:0][COLS-1:0] r_board;
    logic [2:0]                r_piece;
    logic [1:0]                r_orient;
    logic signed [5:0]         r_orow, r_ocol;
    logic [RW-1:0]             r_scan;
    logic                      r_fallPend;
    logic [15:0]               r_lines;
    logic [2*ROWS*COLS-1:0]    r_field, w_fieldNext;

    logic [2:0]                w_spawnPiece, w_candPiece;
    logic [1:0]                w_candOrient;
    logic signed [5:0]         w_candRow, w_candCol;
    logic [15:0]               w_candCells, w_cells;
    logic                      w_collide, w_fallReq, w_rowFull;
    logic [RW-1:0]             w_cellRow [4];
    logic [CW-1:0]             w_cellCol [4];

    // Each cell is packed as {row[1:0], col[1:0]} within the 4x4 box.
    function automatic logic [15:0] shapeCells(input logic [2:0] piece, input logic [1:0] orient);
        logic [15:0] cells;
        logic [1:0]  rr, cc;
        case (piece)
            3'd1:    cells = {4'b0001, 4'b0010, 4'b0101, 4'b0110};
            3'd2:    cells = {4'b0001, 4'b0100, 4'b0101, 4'b0110};
            3'd3:    cells = {4'b0010, 4'b0100, 4'b0101, 4'b0110};
            3'd4:    cells = {4'b0000, 4'b0001, 4'b0101, 4'b0110};
            default: cells = {4'b0100, 4'b0101, 4'b0110, 4'b0111};
        endcase
        if (piece != 3'd1) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(orient)) begin
                    for (int i = 0; i < 4; i++) begin
                        rr = cells[i*4+2 +: 2];
                        cc = cells[i*4 +: 2];
                        cells[i*4 +: 4] = {cc, ~rr};
                    end
                end
            end
        end
        return cells;
    endfunction

    function automatic logic collides(input logic [ROWS-1:0][COLS-1:0] board,
                                      input logic [15:0] cells,
                                      input logic signed [5:0] orow,
                                      input logic signed [5:0] ocol);
        logic signed [6:0] row, col;
        logic              hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row = $signed({orow[5], orow}) + $signed({5'b0, cells[i*4+2 +: 2]});
            col = $signed({ocol[5], ocol}) + $signed({5'b0, cells[i*4 +: 2]});
            if (col[6] || col[5:0] >= 6'(COLS) || row[6] || row[5:0] >= 6'(ROWS))
                hit = 1'b1;
            else if (board[row[RW-1:0]][col[CW-1:0]])
                hit = 1'b1;
        end
        return hit;
    endfunction

    assign w_spawnPiece = (random5 >= 3'd5) ? (random5 - 3'd5) : random5;
    assign w_fallReq    = !tick_move && (tick_fall || r_fallPend);
    assign w_rowFull    = &r_board[r_scan];
    assign w_cells      = shapeCells(r_piece, r_orient);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cellRow[i] = RW'(r_orow) + RW'(w_cells[i*4+2 +: 2]);
            w_cellCol[i] = CW'(r_ocol) + CW'(w_cells[i*4 +: 2]);
        end
    end

    // One candidate position per cycle; a move on tick_move defers any fall to the next cycle.
    always_comb begin
        w_candPiece  = r_piece;
        w_candOrient = r_orient;
        w_candRow    = r_orow;
        w_candCol    = r_ocol;
        case (r_state)
            S_SPAWN: begin
                w_candPiece  = w_spawnPiece;
                w_candOrient = 2'd0;
                w_candRow    = 6'sd0;
                w_candCol    = 6'(SPAWN_COL);
            end
            S_PLAY: begin
                if (tick_move) begin
                    if (rotate_i)
                        w_candOrient = r_orient + 2'd1;
                    else if (left_i && !right_i)
                        w_candCol = r_ocol - 6'sd1;
                    else if (right_i && !left_i)
                        w_candCol = r_ocol + 6'sd1;
                end else begin
                    w_candRow = r_orow + 6'sd1;
                end
            end
            default: ;
        endcase
    end

    assign w_candCells = shapeCells(w_candPiece, w_candOrient);
    assign w_collide   = collides(r_board, w_candCells, w_candRow, w_candCol);

    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= S_SPAWN;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_SPAWN:    w_nextState = w_collide ? S_GAMEOVER : S_PLAY;
            S_PLAY:     if (w_fallReq && w_collide) w_nextState = S_LOCK;
            S_LOCK:     w_nextState = S_CLEAR;
            S_CLEAR:    if (!w_rowFull && r_scan == '0) w_nextState = S_SPAWN;
            S_GAMEOVER: w_nextState = S_GAMEOVER;
            default:    w_nextState = S_SPAWN;
        endcase
    end

    always_comb begin
        w_fieldNext = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_fieldNext[(r*COLS+c)*2] = r_board[r][c];
        if (r_state == S_PLAY)
            for (int i = 0; i < 4; i++)
                w_fieldNext[(int'(w_cellRow[i])*COLS + int'(w_cellCol[i]))*2 +: 2] = 2'b10;
        game_over = (r_state == S_GAMEOVER);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_board    <= '0;
            r_piece    <= '0;
            r_orient   <= '0;
            r_orow     <= '0;
            r_ocol     <= '0;
            r_scan     <= '0;
            r_fallPend <= 1'b0;
            r_lines    <= '0;
            r_field    <= '0;
        end else begin
            r_field <= w_fieldNext;
            case (r_state)
                S_SPAWN: begin
                    r_piece    <= w_candPiece;
                    r_orient   <= w_candOrient;
                    r_orow     <= w_candRow;
                    r_ocol     <= w_candCol;
                    r_fallPend <= 1'b0;
                end
                S_PLAY: begin
                    if (tick_move) begin
                        if (!w_collide) begin
                            r_orient <= w_candOrient;
                            r_ocol   <= w_candCol;
                        end
                        r_fallPend <= r_fallPend | speed_i | tick_fall;
                    end else if (w_fallReq) begin
                        r_fallPend <= 1'b0;
                        if (!w_collide)
                            r_orow <= w_candRow;
                    end
                end
                S_LOCK: begin
                    for (int i = 0; i < 4; i++)
                        r_board[w_cellRow[i]][w_cellCol[i]] <= 1'b1;
                    r_scan <= RW'(ROWS-1);
                end
                S_CLEAR: begin
                    // A full row collapses everything above it and the same row index is rescanned.
                    if (w_rowFull) begin
                        for (int r = 1; r < ROWS; r++)
                            if (RW'(r) <= r_scan)
                                r_board[r] <= r_board[r-1];
                        r_board[0] <= '0;
                        r_lines    <= r_lines + 16'd1;
                    end else if (r_scan != '0) begin
                        r_scan <= r_scan - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign field = r_field;
    assign lines = r_lines;

endmodule
